// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns a decoded memory access into one
// req/gnt (+ rvalid) bus transaction and holds the core stalled until it ends.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  memwritefrmt,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             mis_q;
  logic             err_q;

  // Access context captured when the access is accepted in IDLE.
  logic             is_load_q;
  logic [2:0]       ld_op_q;
  logic [1:0]       off_q;
  logic [31:2]      waddr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;

  logic             start;
  logic             mis_now;
  logic [35:0]      lanes_now;
  logic             in_req;

  // Size code: loads use ld_op[1:0], stores the width code; 00 byte,
  // 01 half, anything else is a full word.
  function automatic logic is_misaligned(input logic load, input logic [2:0] op,
                                         input logic [1:0] fmt, input logic [1:0] o);
    logic [1:0] sz;
    sz = load ? op[1:0] : fmt;
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return o[0];
      default: return |o;
    endcase
  endfunction

  // Byte enables and lane-replicated write data for a store.
  function automatic logic [35:0] store_lanes(input logic [1:0] fmt, input logic [1:0] o,
                                              input logic [31:0] d);
    logic [3:0] be;
    case (fmt)
      2'b00: begin
        be = 4'b0001 << o;
        return {be, {4{d[7:0]}}};
      end
      2'b01: begin
        be = o[1] ? 4'b1100 : 4'b0011;
        return {be, {2{d[15:0]}}};
      end
      default: return {4'b1111, d};
    endcase
  endfunction

  // Select the addressed lane of the returned word and extend it.
  function automatic logic [31:0] ext_load(input logic [2:0] op, input logic [1:0] o,
                                           input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = d >> {o, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign start     = mem_read | mem_write;
  assign mis_now   = is_misaligned(mem_read, ld_op, memwritefrmt, addr[1:0]);
  assign lanes_now = store_lanes(memwritefrmt, addr[1:0], wdata);
  assign cnt_inc   = cnt + 1'b1;
  assign in_req    = (state == REQ);

  assign stall     = ((state == IDLE) & start) | (state == REQ) | (state == WAIT_R);
  assign done      = (state == DONE);
  assign rdata     = done ? rdata_q : 32'h0;
  assign misalign  = done & mis_q;
  assign bus_err   = done & err_q;
  assign bus_req   = in_req;
  assign bus_we    = in_req & ~is_load_q;
  assign bus_addr  = in_req ? {waddr_q, 2'b00} : 32'h0;
  assign bus_be    = in_req ? be_q : 4'h0;
  assign bus_wdata = in_req ? wdata_q : 32'h0;

  // Control FSM, timeout counter and completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mis_q <= mis_now;
            err_q <= 1'b0;
            state <= mis_now ? DONE : REQ;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            cnt   <= '0;
            state <= is_load_q ? WAIT_R : DONE;
          end
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            state <= DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TO_CNT) begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Access context and load result; qualified by state, so no reset needed.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && start) begin
      is_load_q <= mem_read;
      ld_op_q   <= ld_op;
      off_q     <= addr[1:0];
      waddr_q   <= addr[31:2];
      be_q      <= mem_read ? 4'b1111 : lanes_now[35:32];
      wdata_q   <= mem_read ? 32'h0 : lanes_now[31:0];
      rdata_q   <= 32'h0;
    end else if ((state == WAIT_R) && bus_rvalid) begin
      rdata_q   <= ext_load(ld_op_q, off_q, bus_rdata);
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: a driver issues accesses and queues the
// expected bus request and completion; monitors compare as the DUT presents them.
module tb_lsu_bus_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  ld_op = 3'b0;
  logic [1:0]  memwritefrmt = 2'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        stall, done, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  lsu_bus_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .ld_op(ld_op), .memwritefrmt(memwritefrmt), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } bus_t;
  typedef struct { logic [31:0] rdata; logic mis; logic err; } done_t;
  bus_t  bus_q[$];
  done_t done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Responder knobs, set by the driver per access.
  int          gnt_delay = 0, rv_delay = 0;
  bit          rv_never = 0, late_rv = 0;
  logic [31:0] rd_val = 32'h0;
  int          req_cnt = 0, wcnt = 0;
  bit          waiting = 0;

  // Bus slave model: grant after gnt_delay REQ cycles, answer reads after
  // rv_delay WAIT cycles; outside an outstanding read it drives random noise.
  always @(negedge clk) begin
    if (rst) begin
      waiting = 0; req_cnt = 0;
      bus_gnt = 1'b0;
      bus_rvalid = late_rv;
      bus_rdata = $urandom;
    end else begin
      if (done) waiting = 0;
      if (waiting) begin
        if (!rv_never && wcnt == rv_delay) begin
          bus_rvalid = 1'b1; bus_rdata = rd_val; waiting = 0;
        end else begin
          bus_rvalid = 1'b0; bus_rdata = $urandom;
        end
        wcnt++;
      end else begin
        bus_rvalid = late_rv ? 1'b1 : 1'($urandom_range(0, 1));
        bus_rdata  = $urandom;
      end
      if (bus_req) begin
        if (req_cnt == gnt_delay) begin
          bus_gnt = 1'b1; req_cnt = 0;
          if (!bus_we) begin waiting = 1; wcnt = 0; end
        end else begin
          bus_gnt = 1'b0; req_cnt++;
        end
      end else begin
        bus_gnt = 1'($urandom_range(0, 1)); req_cnt = 0;
      end
    end
  end

  // Monitor: bus request fields, their stability, and completion results.
  bit   req_seen = 0, cur_ok = 0;
  bus_t cur;
  done_t dexp;
  always @(negedge clk) begin
    if (bus_req && !req_seen) begin
      req_seen = 1;
      if (bus_q.size() == 0) begin
        cur_ok = 0; checks++; errors++;
        $display("FAIL unexpected_bus_req actual=1 required=0 addr=%h", bus_addr);
      end else begin
        cur = bus_q.pop_front(); cur_ok = 1;
        chk("bus_addr", bus_addr, cur.addr);
        chk("bus_we", 32'(bus_we), 32'(cur.we));
        chk("bus_be", 32'(bus_be), 32'(cur.be));
        if (cur.we) chk("bus_wdata", bus_wdata, cur.wdata);
      end
    end else if (bus_req && cur_ok) begin
      chk("bus_addr_stable", bus_addr, cur.addr);
      chk("bus_be_stable", 32'(bus_be), 32'(cur.be));
    end
    if (!bus_req) req_seen = 0;
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        dexp = done_q.pop_front();
        chk("rdata", rdata, dexp.rdata);
        chk("misalign", 32'(misalign), 32'(dexp.mis));
        chk("bus_err", 32'(bus_err), 32'(dexp.err));
      end
    end else if (!rst) begin
      chk("rdata_idle_zero", rdata, 32'h0);
    end
  end

  // Reference model of one access from the architectural rules.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] op,
                         input logic [1:0] fmt, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv,
                         input int gd, input int rvd, input bit never);
    int    size, exp_stall, n, cyc;
    bit    mis;
    bus_t  b;
    done_t d;
    logic [31:0] sh, v;
    gnt_delay = gd; rv_delay = rvd; rv_never = never; rd_val = rdv;
    if (rd) size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    else    size = (fmt == 2'd0) ? 1 : (fmt == 2'd1) ? 2 : 4;
    mis = (a % size) != 0;
    d.rdata = 32'h0; d.mis = mis; d.err = 1'b0;
    if (mis) begin
      exp_stall = 1;
    end else begin
      b.addr = a & 32'hFFFF_FFFC;
      b.we   = !rd;
      if (rd) begin
        b.be = 4'hF; b.wdata = 32'h0;
      end else if (size == 1) begin
        b.be = 4'(1 << (a % 4)); b.wdata = (wd & 32'hFF) * 32'h0101_0101;
      end else if (size == 2) begin
        b.be = 4'(3 << (a % 4)); b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
      end else begin
        b.be = 4'hF; b.wdata = wd;
      end
      bus_q.push_back(b);
      if (!rd) begin
        exp_stall = 2 + gd;
      end else if (never) begin
        d.err = 1'b1; exp_stall = 2 + gd + TO;
      end else begin
        exp_stall = 3 + gd + rvd;
        sh = rdv >> (8 * (a % 4));
        case (op)
          3'b000: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
          3'b001: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
          3'b100: v = sh & 32'hFF;
          3'b101: v = sh & 32'hFFFF;
          default: v = rdv;
        endcase
        d.rdata = v;
      end
    end
    done_q.push_back(d);
    mem_read = rd; mem_write = wr; ld_op = op; memwritefrmt = fmt; addr = a; wdata = wd;
    n = 0; cyc = 0;
    #1;
    forever begin
      if (stall) n++;
      @(negedge clk); #1;
      if (done) break;
      cyc++;
      if (cyc > 60) begin
        checks++; errors++;
        $display("FAIL done_timeout actual=none required=done");
        break;
      end
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    chk("stall_in_done", 32'(stall), 32'h0);
  endtask

  task automatic idle_inputs(input int cycles);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {stall, done, misalign, bus_err, bus_req, bus_we, bus_be}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_bus_addr", bus_addr, 32'h0);
    #1 rst = 1'b0;
    idle_inputs(2);

    run_txn(0, 1, 3'b000, 2'b00, 32'h1003, 32'h0000_00A5, 32'h0, 1, 0, 0);
    idle_inputs(1);
    run_txn(1, 0, 3'b000, 2'b00, 32'h2001, 32'h0, 32'h1234_F0CD, 0, 0, 0);
    idle_inputs(1);
    run_txn(1, 0, 3'b100, 2'b00, 32'h2001, 32'h0, 32'h1234_F0CD, 0, 0, 0);
    idle_inputs(1);
    run_txn(1, 0, 3'b001, 2'b00, 32'h3002, 32'h0, 32'h8001_7FFF, 0, 1, 0);
    idle_inputs(1);
    run_txn(1, 0, 3'b101, 2'b00, 32'h3002, 32'h0, 32'h8001_7FFF, 2, 3, 0);
    idle_inputs(1);
    run_txn(1, 0, 3'b010, 2'b00, 32'h4002, 32'h0, 32'h0, 0, 0, 0);
    idle_inputs(1);
    run_txn(0, 1, 3'b000, 2'b01, 32'h4001, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    idle_inputs(1);
    run_txn(1, 0, 3'b010, 2'b00, 32'h5000, 32'h0, 32'h0, 1, 0, 1);
    late_rv = 1; idle_inputs(4); late_rv = 0;

    // Reset while a read is outstanding, followed by a stray rvalid.
    b_push_for_reset();
    mem_read = 1'b1; mem_write = 1'b0; ld_op = 3'b010; addr = 32'h6000;
    gnt_delay = 0; rv_never = 1;
    w = 0;
    while (!waiting && w < 20) begin @(negedge clk); #1; w++; end
    chk("reached_wait", 32'(waiting), 32'h1);
    @(negedge clk); #1;
    rst = 1'b1; mem_read = 1'b0; late_rv = 1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("post_reset_ctrl", {stall, done, misalign, bus_err, bus_req, bus_we, bus_be}, 32'h0);
    chk("post_reset_rdata", rdata, 32'h0);
    chk("post_reset_bus_addr", bus_addr, 32'h0);
    idle_inputs(4); late_rv = 0; rv_never = 0;

    run_txn(0, 1, 3'b000, 2'b10, 32'h7004, 32'hCAFE_F00D, 32'h0, 0, 0, 0);
    run_txn(1, 0, 3'b010, 2'b00, 32'h7004, 32'h0, 32'hCAFE_F00D, 1, 2, 0);
    idle_inputs(2);

    for (int i = 0; i < 40; i++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(rd, wr, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, TO - 1), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 1) == 1) idle_inputs($urandom_range(1, 3));
    end
    idle_inputs(3);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // The aborted read still issues its bus request before the reset.
  task automatic b_push_for_reset();
    bus_t b;
    b.addr = 32'h6000; b.we = 1'b0; b.be = 4'hF; b.wdata = 32'h0;
    bus_q.push_back(b);
  endtask

endmodule
